// File: rtl/song_reader_pkg.sv
// rtl/song_reader_pkg.sv - song ROM entry layout, sequencer states and entry decode
package song_pkg;

  localparam int SONG_W    = 2;
  localparam int IDX_W     = 5;

  localparam int ADV_BIT   = 15;
  localparam int NOTE_MSB  = 14;
  localparam int NOTE_LSB  = 9;
  localparam int DUR_MSB   = 8;
  localparam int DUR_LSB   = 3;
  localparam int BEATS_MSB = 14;
  localparam int BEATS_LSB = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ROMWAIT,
    ST_DECODE,
    ST_WAIT,
    ST_DONE
  } song_state_t;

  typedef struct packed {
    logic       is_advance;
    logic [5:0] note;
    logic [5:0] dur;
    logic [5:0] beats;
    logic [2:0] rsvd;
  } song_entry_t;

  function automatic song_entry_t decode_entry(input logic [15:0] word);
    song_entry_t e;
    e.is_advance = word[ADV_BIT];
    e.note       = word[NOTE_MSB:NOTE_LSB];
    e.dur        = word[DUR_MSB:DUR_LSB];
    e.beats      = word[BEATS_MSB:BEATS_LSB];
    e.rsvd       = word[2:0];
    return e;
  endfunction

endpackage

// File: rtl/song_reader_voice_alloc.sv
// rtl/song_reader_voice_alloc.sv - picks the lowest free voice, else steals round-robin
module voice_alloc #(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_VOICES-1:0] voice_busy,
  input  logic                  steal,
  output logic [NUM_VOICES-1:0] sel,
  output logic                  all_busy
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [PTR_W-1:0]      steal_ptr;
  logic [NUM_VOICES-1:0] free_sel;
  logic [NUM_VOICES-1:0] steal_sel;
  logic                  found;

  always_comb begin
    free_sel  = '0;
    steal_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found && !voice_busy[i]) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
      if (steal_ptr == PTR_W'(i)) begin
        steal_sel[i] = 1'b1;
      end
    end
    all_busy = &voice_busy;
    sel      = all_busy ? steal_sel : free_sel;
  end

  // Pointer only moves when a steal is actually committed to a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steal_ptr <= '0;
    end else if (steal) begin
      if (steal_ptr == PTR_W'(NUM_VOICES - 1)) begin
        steal_ptr <= '0;
      end else begin
        steal_ptr <= steal_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - song ROM sequencer feeding note voices; SONG_READER_LOOP_EN repeats songs
module song_reader #(
  parameter int NUM_VOICES = 3,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  restart,
  input  logic [1:0]            song_sel,
  input  logic                  beat,
  output logic [IDX_W+1:0]      rom_addr,
  input  logic [15:0]           rom_dout,
  input  logic [NUM_VOICES-1:0] voice_busy,
  output logic [NUM_VOICES-1:0] load,
  output logic [5:0]            note,
  output logic [5:0]            duration,
  output logic                  song_done
);

  import song_pkg::*;

  song_state_t           state;
  logic [1:0]            song;
  logic [IDX_W-1:0]      idx;
  logic [5:0]            beat_cnt;
  song_entry_t           ent;
  logic                  step;
  logic                  fin;
  logic                  steal;
  logic                  all_busy;
  logic [NUM_VOICES-1:0] voice_sel;
  logic                  unused_bits;

  assign ent         = decode_entry(rom_dout);
  assign unused_bits = ^ent.rsvd;

  voice_alloc #(
    .NUM_VOICES(NUM_VOICES)
  ) u_voice_alloc (
    .clk       (clk),
    .reset_n   (reset_n),
    .voice_busy(voice_busy),
    .steal     (steal),
    .sel       (voice_sel),
    .all_busy  (all_busy)
  );

  // step: move to the next entry; fin: song is over (end marker or last index consumed).
  always_comb begin
    step  = 1'b0;
    fin   = 1'b0;
    steal = 1'b0;
    if (!restart && play) begin
      case (state)
        ST_DECODE: begin
          if (!ent.is_advance) begin
            step  = 1'b1;
            steal = all_busy;
          end else if (ent.beats == 6'd0) begin
            fin = 1'b1;
          end
        end
        ST_WAIT: begin
          if (beat && beat_cnt == 6'd1) begin
            step = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (step && (&idx)) begin
      step = 1'b0;
      fin  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      song      <= '0;
      idx       <= '0;
      beat_cnt  <= '0;
      rom_addr  <= '0;
      load      <= '0;
      note      <= '0;
      duration  <= '0;
      song_done <= 1'b0;
    end else begin
      load      <= '0;
      song_done <= (state == ST_DONE);
      if (restart) begin
        state     <= ST_IDLE;
        idx       <= '0;
        song_done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            song <= song_sel;
            if (play) begin
              state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (play) begin
              rom_addr <= {song, idx};
              state    <= ST_ROMWAIT;
            end
          end
          ST_ROMWAIT: begin
            if (play) begin
              state <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            if (play) begin
              if (!ent.is_advance) begin
                note     <= ent.note;
                duration <= ent.dur;
                load     <= voice_sel;
              end else if (ent.beats != 6'd0) begin
                beat_cnt <= ent.beats;
                state    <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (play && beat && beat_cnt != 6'd1) begin
              beat_cnt <= beat_cnt - 6'd1;
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase

        if (fin) begin
          song_done <= 1'b1;
`ifdef SONG_READER_LOOP_EN
          idx   <= '0;
          state <= ST_FETCH;
`else
          state <= ST_DONE;
`endif
        end else if (step) begin
          idx   <= idx + 1'b1;
          state <= ST_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - directed bench for song_reader in its default (non-looping) build
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic        restart;
  logic [1:0]  song_sel;
  logic        beat;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [2:0]  voice_busy;
  logic [2:0]  load;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;

  logic [15:0] rom [0:127];
  int          total = 0;
  int          bad   = 0;
  int          load_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_dout <= rom[rom_addr];
    if (load != 3'b000) load_cnt <= load_cnt + 1;
  end

  song_reader #(.NUM_VOICES(3), .IDX_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .restart   (restart),
    .song_sel  (song_sel),
    .beat      (beat),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .voice_busy(voice_busy),
    .load      (load),
    .note      (note),
    .duration  (duration),
    .song_done (song_done)
  );

  function automatic logic [15:0] note_e(input int n, input int d);
    logic [5:0] nn;
    logic [5:0] dd;
    nn = n[5:0];
    dd = d[5:0];
    return {1'b0, nn, dd, 3'b000};
  endfunction

  function automatic logic [15:0] adv_e(input int b);
    logic [5:0] bb;
    bb = b[5:0];
    return {1'b1, bb, 9'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_beat;
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_restart(input logic [1:0] s);
    song_sel = s;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
  endtask

  task automatic wait_addr(input logic [6:0] target, input string tag);
    int n;
    n = 0;
    while (rom_addr !== target && n < 200) begin
      tick();
      n++;
    end
    check(tag, {25'd0, rom_addr}, {25'd0, target});
  endtask

  logic [2:0] busy_pat [0:5];
  logic [2:0] exp_load [0:5];

  initial begin
    int n;
    int k;
    int seen;
    int lc;
    logic [6:0] addr_hold;

    for (int i = 0; i < 128; i++) rom[i] = note_e(1, 1);
    rom[0] = note_e(40, 48);
    rom[1] = adv_e(12);
    rom[2] = adv_e(0);
    for (int i = 0; i < 6; i++) rom[32 + i] = note_e(10 + i, 5);
    rom[38] = adv_e(0);
    rom[64] = note_e(20, 20);
    rom[65] = adv_e(0);
    rom[96] = adv_e(8);
    rom[97] = adv_e(0);

    busy_pat = '{3'b001, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
    exp_load = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001};

    reset_n    = 1'b0;
    play       = 1'b1;
    restart    = 1'b0;
    song_sel   = 2'd0;
    beat       = 1'b0;
    voice_busy = 3'b000;
    tick();
    tick();
    check("rst_load", {29'd0, load}, 32'd0);
    check("rst_addr", {25'd0, rom_addr}, 32'd0);
    check("rst_done", {31'd0, song_done}, 32'd0);
    check("rst_note", {26'd0, note}, 32'd0);
    check("rst_dur", {26'd0, duration}, 32'd0);
    reset_n = 1'b1;

    // first note: FETCH follows the first edge, load three cycles later
    n = 0;
    while (load === 3'b000 && n < 20) begin
      tick();
      n++;
    end
    check("t1_latency", n, 4);
    check("t1_load", {29'd0, load}, 32'd1);
    check("t1_note", {26'd0, note}, 32'd40);
    check("t1_dur", {26'd0, duration}, 32'd48);
    tick();
    check("t1_load_pulse", {29'd0, load}, 32'd0);
    tick();
    tick();
    k = 0;
    while (rom_addr !== 7'd2 && k < 20) begin
      pulse_beat();
      k++;
    end
    check("t1_beats", k, 12);
    tick();
    tick();
    check("t1_done", {31'd0, song_done}, 32'd1);

    // voice selection: free voice then steal rotation
    voice_busy = busy_pat[0];
    pulse_restart(2'd1);
    check("t2_done_clr", {31'd0, song_done}, 32'd0);
    seen = 0;
    n = 0;
    while (seen < 6 && n < 200) begin
      tick();
      n++;
      if (load !== 3'b000) begin
        check("t2_load", {29'd0, load}, {29'd0, exp_load[seen]});
        check("t2_note", {26'd0, note}, 10 + seen);
        seen++;
        if (seen < 6) voice_busy = busy_pat[seen];
      end
    end
    check("t2_loads_seen", seen, 6);
    voice_busy = 3'b000;
    n = 0;
    while (song_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t2_done", {31'd0, song_done}, 32'd1);
    check("t2_end_addr", {25'd0, rom_addr}, 32'd38);
    lc = load_cnt;
    addr_hold = rom_addr;
    for (int i = 0; i < 100; i++) pulse_beat();
    check("t2_no_loads", load_cnt - lc, 0);
    check("t2_addr_frozen", {25'd0, rom_addr}, {25'd0, addr_hold});
    check("t2_still_done", {31'd0, song_done}, 32'd1);

    // pause mid-WAIT
    pulse_restart(2'd3);
    wait_addr(7'd96, "t3_addr96");
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) pulse_beat();
    play = 1'b0;
    for (int i = 0; i < 5; i++) pulse_beat();
    check("t3_paused_addr", {25'd0, rom_addr}, 32'd96);
    play = 1'b1;
    k = 0;
    while (rom_addr !== 7'd97 && k < 20) begin
      pulse_beat();
      k++;
    end
    check("t3_play_beats", 3 + k, 8);
    tick();
    tick();
    check("t3_done", {31'd0, song_done}, 32'd1);

    // restart during ROMWAIT selects a new song
    pulse_restart(2'd3);
    check("t4_done_clr", {31'd0, song_done}, 32'd0);
    wait_addr(7'd96, "t4_addr96");
    pulse_restart(2'd2);
    check("t4_idle_done", {31'd0, song_done}, 32'd0);
    check("t4_idle_load", {29'd0, load}, 32'd0);
    tick();
    check("t4_fetch_pending", {25'd0, rom_addr}, 32'd96);
    tick();
    check("t4_addr64", {25'd0, rom_addr}, 32'd64);
    tick();
    tick();
    check("t4_load", {29'd0, load}, 32'd1);
    check("t4_note", {26'd0, note}, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Sequencer directly downstream of the 128x16 song ROM.
- Drives the ROM address, absorbs its 1-cycle registered read latency, and decodes each 16-bit entry.
- Note entries are dispatched to one of several note-player voices; advance entries stall the sequence for a number of beats.
- Sits between the song ROM and the note players / beat generator.

Parameters:
- NUM_VOICES, 3, number of note-player voices fed; range 1..8.
- IDX_W, 5, entry-index width within one song; 4 songs x 32 entries = 128 ROM words.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- play  in  1  level; 1 = run, 0 = pause.
- restart  in  1  one-cycle pulse; return to entry 0 of the selected song.
- song_sel  in  2  song number; sampled only in IDLE.
- beat  in  1  one-cycle tick from the beat generator.
- rom_addr  out  7  {song, idx}; drives the ROM address.
- rom_dout  in  16  ROM data; valid the cycle after rom_addr is presented.
- voice_busy  in  NUM_VOICES  per-voice "note still sounding".
- load  out  NUM_VOICES  one-hot, one-cycle strobe to the selected voice.
- note  out  6  note number to the voices.
- duration  out  6  note duration to the voices.
- song_done  out  1  level; high in DONE.

Behaviour:
- Entry format:
  - bit15 = 0 is a note entry: note = [14:9], duration = [8:3], [2:0] ignored.
  - bit15 = 1 is an advance entry: beats = [14:9], [8:0] ignored.
  - Advance with beats = 0 is the end-of-song marker.
- Reset (async assert, sync release): state IDLE, idx = 0, song = 0, rom_addr = 0, load = 0, note = 0, duration = 0, song_done = 0, beat counter = 0, steal pointer = 0.
- States: IDLE, FETCH, ROMWAIT, DECODE, WAIT, DONE.
- IDLE:
  - song latched from song_sel every cycle.
  - play = 1 -> FETCH.
- FETCH: rom_addr = {song, idx} -> ROMWAIT.
- ROMWAIT: one cycle for the ROM read latency -> DECODE.
- DECODE, note entry:
  - Present note and duration; assert load on exactly one voice for one cycle.
  - Voice choice: lowest-index voice with voice_busy = 0.
  - If all voices are busy, steal the voice at the steal pointer; the pointer then increments modulo NUM_VOICES.
  - Then idx advances -> FETCH.
- DECODE, advance entry with beats > 0: load counter = beats -> WAIT.
- DECODE, advance entry with beats = 0: -> DONE.
- WAIT:
  - Each beat while play = 1 decrements the counter.
  - A beat with counter = 1: idx advances -> FETCH.
  - A beat in the same cycle as entry into WAIT is not counted.
- idx wrap: after processing idx = 31 with no end marker -> DONE; idx does not wrap into the next song.
- Pause (play = 0):
  - FETCH, ROMWAIT and DECODE hold state; no load is issued.
  - WAIT ignores beats; the counter is frozen.
  - Resuming continues exactly where it stopped.
- DONE:
  - song_done = 1; no loads.
  - Stays in DONE until restart.
- restart (any state, highest priority over all other transitions): idx = 0 -> IDLE; song_done clears next cycle.
- note and duration hold their last value between loads.
- Minimum spacing between consecutive loads is 3 cycles (FETCH, ROMWAIT, DECODE).

Optional Feature:
- Macro SONG_READER_LOOP_EN.
- Defined: end marker or idx = 31 completion sets idx = 0 -> FETCH (song repeats). song_done still pulses high for one cycle at the wrap.
- Undefined: behaviour as above; DONE is terminal until restart.

Decomposition:
- Shared package song_pkg:
  - Entry field positions/widths: NOTE_MSB/LSB, DUR_MSB/LSB, ADV_BIT, BEATS_MSB/LSB.
  - State enum song_state_t.
  - SONG_W = 2 and IDX_W.
  - A decode function returning {is_advance, note, dur, beats}.
- One natural sub-module, voice_alloc:
  - Combinational priority encoder over voice_busy, plus the registered steal pointer.
  - Outputs a one-hot voice select.

Test Plan:
- Reset with song_sel = 0, play = 1, entries {note 40 dur 48}, {adv 12}:
  - One-cycle load[0] with note = 40, duration = 48 three cycles after FETCH.
  - Exactly 12 beats later, rom_addr = 2.
- voice_busy = 3'b001 at a note entry -> load = 3'b010.
- voice_busy = 3'b111 across three notes -> loads 001, 010, 100 (steal rotation).
- Advance with beats = 0 at idx 6 -> song_done = 1; no further loads or rom_addr changes over 100 beats.
- With SONG_READER_LOOP_EN: rom_addr returns to idx 0 after the end marker.
- play dropped mid-WAIT for 5 beats, then raised:
  - Remaining beat count is unchanged.
  - Total beats of play = 1 still equal the advance value.
- restart asserted during ROMWAIT with song_sel = 2:
  - IDLE next cycle; song_done = 0.
  - Next FETCH drives rom_addr = 64.
